// File: rtl/tikhonov_pkg.sv
// Shared constants for the Tikhonov pseudo-inverse datapath.
// Holds the scheduler state encoding, the per-bin matrix stride and the
// address/bin widths that the scheduler and the inverse engine agree on.
package tikhonov_pkg;

  localparam int TIK_FREQ_NUM       = 257;
  localparam int TIK_MIC_NUM        = 8;
  localparam int TIK_SOR_NUM        = 2;
  localparam int PER_FREQ           = TIK_MIC_NUM * TIK_SOR_NUM;   // words per bin
  localparam int TOTAL_NUM          = TIK_FREQ_NUM * PER_FREQ;     // words per frame
  localparam int TIK_ADDR_WIDTH     = 13;
  localparam int TIK_BIN_WIDTH      = 9;
  localparam int TIK_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_NEXT  = 3'd3,
    S_FIN   = 3'd4,
    S_ERR   = 3'd5
  } sched_state_e;

endpackage

// File: rtl/tik_wdog_cnt.sv
// Per-bin watchdog counter for the bin scheduler.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   load_i    : clear the count (engine start issued)
//   run_i     : count one cycle (waiting on the engine)
//   expire_o  : high in the LIMIT-th consecutive run cycle
module tik_wdog_cnt #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic run_i,
  output logic expire_o
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire_o = run_i && (cnt_q == CW'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                 cnt_d = '0;
    else if (run_i && !expire_o) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tikhonov_bin_scheduler.sv
// Walks the single Tikhonov inverse engine over every frequency bin of a frame.
// Each bin: one eng_start pulse with that bin's A/W base addresses, then wait
// for eng_done. done pulses once after the last bin.
// Optional feature macro: TIK_SCHED_WDOG_EN (per-bin watchdog, ERR state, sticky error).
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   start, abort             : frame start request / synchronous frame abort
//   eng_done                 : completion pulse from the engine
//   eng_start                : start pulse to the engine
//   eng_rd_base, eng_wr_base : A read / W write base for the current bin
//   bin_idx                  : current bin
//   busy, done, error        : status
module tikhonov_bin_scheduler
  import tikhonov_pkg::*;
#(
  parameter int FREQ_NUM   = TIK_FREQ_NUM,
  parameter int MIC_NUM    = TIK_MIC_NUM,
  parameter int SOR_NUM    = TIK_SOR_NUM,
  parameter int ADDR_WIDTH = TIK_ADDR_WIDTH,
  parameter int BIN_WIDTH  = TIK_BIN_WIDTH
`ifdef TIK_SCHED_WDOG_EN
  , parameter int TIMEOUT_CYCLES = TIK_TIMEOUT_CYCLES
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  eng_done,
  output logic                  eng_start,
  output logic [ADDR_WIDTH-1:0] eng_rd_base,
  output logic [ADDR_WIDTH-1:0] eng_wr_base,
  output logic [BIN_WIDTH-1:0]  bin_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  // Bases advance by a constant stride per bin instead of bin*stride.
  localparam logic [ADDR_WIDTH-1:0] STRIDE   = ADDR_WIDTH'(MIC_NUM * SOR_NUM);
  localparam logic [BIN_WIDTH-1:0]  LAST_BIN = BIN_WIDTH'(FREQ_NUM - 1);

  sched_state_e          state_q, state_d;
  logic [BIN_WIDTH-1:0]  bin_q, bin_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [ADDR_WIDTH-1:0] wr_q, wr_d;

`ifdef TIK_SCHED_WDOG_EN
  logic error_q, error_d;
  logic wdog_expire;

  tik_wdog_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .load_i   (state_q == S_ISSUE),
    .run_i    (state_q == S_WAIT),
    .expire_o (wdog_expire)
  );
`endif

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
`ifdef TIK_SCHED_WDOG_EN
    error_d = error_q;
`endif
    // Abort outranks everything else; counters stay put until the next start.
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          state_d = S_ISSUE;
          bin_d   = '0;
          rd_d    = '0;
          wr_d    = '0;
`ifdef TIK_SCHED_WDOG_EN
          error_d = 1'b0;
`endif
        end
        S_ISSUE: state_d = S_WAIT;
        S_WAIT: begin
          if (eng_done) state_d = S_NEXT;
`ifdef TIK_SCHED_WDOG_EN
          else if (wdog_expire) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
`endif
        end
        S_NEXT: begin
          if (bin_q == LAST_BIN) begin
            state_d = S_FIN;
          end else begin
            state_d = S_ISSUE;
            bin_d   = bin_q + BIN_WIDTH'(1);
            rd_d    = rd_q + STRIDE;
            wr_d    = wr_q + STRIDE;
          end
        end
        S_FIN: state_d = S_IDLE;
`ifdef TIK_SCHED_WDOG_EN
        S_ERR: if (start) begin
          state_d = S_ISSUE;
          bin_d   = '0;
          rd_d    = '0;
          wr_d    = '0;
          error_d = 1'b0;
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
`ifdef TIK_SCHED_WDOG_EN
      error_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
`ifdef TIK_SCHED_WDOG_EN
      error_q <= error_d;
`endif
    end
  end

  // Moore outputs: all decode from registered state, so reset zeroes them at once.
  assign eng_start   = (state_q == S_ISSUE);
  assign done        = (state_q == S_FIN);
  assign busy        = (state_q != S_IDLE) && (state_q != S_ERR);
  assign bin_idx     = bin_q;
  assign eng_rd_base = rd_q;
  assign eng_wr_base = wr_q;
`ifdef TIK_SCHED_WDOG_EN
  assign error       = error_q;
`else
  assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_tikhonov_bin_scheduler.sv
`timescale 1ns/1ps
module tb_tikhonov_bin_scheduler;

  localparam int FREQ = 257;
  localparam int PF   = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort_m = 1'b0, abort_a = 1'b0;
  logic        done_m = 1'b0, done_a = 1'b0;
  logic        abort, eng_done;
  logic        eng_start, busy, done, error;
  logic [12:0] eng_rd_base, eng_wr_base;
  logic [8:0]  bin_idx;

  assign abort    = abort_m | abort_a;
  assign eng_done = done_m | done_a;

  always #5 clk = ~clk;

  tikhonov_bin_scheduler #(
`ifdef TIK_SCHED_WDOG_EN
    .TIMEOUT_CYCLES (8),
`endif
    .FREQ_NUM       (FREQ)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .eng_done    (eng_done),
    .eng_start   (eng_start),
    .eng_rd_base (eng_rd_base),
    .eng_wr_base (eng_wr_base),
    .bin_idx     (bin_idx),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  // Engine model: done lands eng_lat cycles after the cycle holding eng_start.
  int eng_lat = 5;
  bit eng_auto = 1'b0;
  int silent_bin = -1;
  int abort_bin = -1;
  int pend = 0;

  always begin
    @(negedge clk);
    if (eng_auto && eng_start && int'(bin_idx) != silent_bin) pend = eng_lat;
    @(posedge clk);
    #1;
    done_a  = 1'b0;
    abort_a = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        done_a = 1'b1;
        if (int'(bin_idx) == abort_bin) abort_a = 1'b1;
      end
    end
  end

  typedef struct { int bin; int base; } exp_t;
  exp_t sb[$];

  int checks = 0, failures = 0;
  int cyc = 0, iss_cnt = 0, last_iss_cyc = 0, done_cnt = 0, done_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One cycle: sample at negedge, pop the scoreboard on every engine start.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (eng_start) begin
      iss_cnt++;
      last_iss_cyc = cyc;
      if (sb.size() == 0) begin
        chk("unexpected_issue", 32'(bin_idx), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("issue_bin", 32'(bin_idx), e.bin);
        chk("issue_rd", 32'(eng_rd_base), e.base);
        chk("issue_wr", 32'(eng_wr_base), e.base);
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic push_frame(input int nbins);
    for (int k = 0; k < nbins; k++) sb.push_back('{k, k * PF});
  endtask

  task automatic pulse_start(output int s);
    start = 1'b1;
    s = cyc;
    step();
    start = 1'b0;
    chk("start_latency", 32'(eng_start), 1);
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      step();
      n++;
    end
    chk("done_seen", 32'(done_cnt - d0), 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_eng_start"}, 32'(eng_start), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_error"}, 32'(error), 0);
    chk({tag, "_bin"}, 32'(bin_idx), 0);
    chk({tag, "_rd"}, 32'(eng_rd_base), 0);
    chk({tag, "_wr"}, 32'(eng_wr_base), 0);
  endtask

  initial begin
    int s, n, d0, i0;

    // Reset state
    step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();
    chk("idle_busy", 32'(busy), 0);

    // Full frame, engine latency 5; a stray start mid-frame must be ignored
    eng_auto = 1'b1; eng_lat = 5; iss_cnt = 0;
    push_frame(FREQ);
    pulse_start(s);
    for (int k = 0; k < 50; k++) step();
    start = 1'b1; step(); start = 1'b0;
    wait_done(4000);
    chk("f1_frame_len", done_cyc, s + 1 + FREQ * 7);
    chk("f1_issues", iss_cnt, FREQ);
    chk("f1_sb_empty", sb.size(), 0);
    chk("f1_busy_at_done", 32'(busy), 1);
    step();
    chk("f1_busy_after", 32'(busy), 0);
    chk("f1_bin_held", 32'(bin_idx), FREQ - 1);
    chk("f1_rd_held", 32'(eng_rd_base), (FREQ - 1) * PF);
    chk("f1_wr_held", 32'(eng_wr_base), (FREQ - 1) * PF);
    d0 = done_cnt;
    for (int k = 0; k < 5; k++) step();
    chk("f1_single_done", done_cnt, d0);

    // Spurious eng_done in IDLE
    i0 = iss_cnt;
    done_m = 1'b1; step(); done_m = 1'b0; step();
    chk("idle_done_busy", 32'(busy), 0);
    chk("idle_done_bin", 32'(bin_idx), FREQ - 1);
    chk("idle_done_rd", 32'(eng_rd_base), (FREQ - 1) * PF);
    chk("idle_done_issues", iss_cnt, i0);

    // Spurious eng_done during ISSUE: block must still wait in WAIT
    eng_auto = 1'b0;
    push_frame(1);
    pulse_start(s);
    done_m = 1'b1; step(); done_m = 1'b0;
    for (int k = 0; k < 3; k++) step();
    chk("issue_done_busy", 32'(busy), 1);
    chk("issue_done_bin", 32'(bin_idx), 0);
    chk("issue_done_issues", iss_cnt, i0 + 1);
    abort_m = 1'b1; step(); abort_m = 1'b0;
    chk("abort_wait_busy", 32'(busy), 0);

    // Abort at bin 100 coinciding with eng_done
    eng_auto = 1'b1; eng_lat = 3; abort_bin = 100; iss_cnt = 0;
    d0 = done_cnt;
    push_frame(FREQ);
    pulse_start(s);
    n = 0;
    while (busy && n < 1000) begin step(); n++; end
    chk("abort_reached", 32'(busy), 0);
    chk("abort_bin", 32'(bin_idx), 100);
    chk("abort_rd", 32'(eng_rd_base), 100 * PF);
    for (int k = 0; k < 10; k++) step();
    chk("abort_issues", iss_cnt, 101);
    chk("abort_no_done", done_cnt, d0);
    sb.delete();
    abort_bin = -1;

    // Restart after abort, back-to-back engine (4-cycle issue spacing)
    eng_lat = 2; iss_cnt = 0;
    push_frame(FREQ);
    pulse_start(s);
    wait_done(2000);
    chk("b2b_frame_len", done_cyc, s + FREQ * 4 + 1);
    chk("b2b_last_issue", last_iss_cyc, s + 1 + (FREQ - 1) * 4);
    chk("b2b_issues", iss_cnt, FREQ);
    chk("b2b_sb_empty", sb.size(), 0);
    step();

`ifdef TIK_SCHED_WDOG_EN
    // Watchdog: engine silent at bin 3, limit 8
    silent_bin = 3; iss_cnt = 0;
    push_frame(4);
    pulse_start(s);
    n = 0;
    while (iss_cnt < 4 && n < 100) begin step(); n++; end
    chk("wd_reach_bin3", 32'(bin_idx), 3);
    for (int k = 0; k < 8; k++) step();
    chk("wd_busy_pre", 32'(busy), 1);
    chk("wd_err_pre", 32'(error), 0);
    step();
    chk("wd_err", 32'(error), 1);
    chk("wd_busy", 32'(busy), 0);
    for (int k = 0; k < 3; k++) step();
    chk("wd_sticky", 32'(error), 1);
    chk("wd_no_reissue", iss_cnt, 4);
    silent_bin = -1; eng_auto = 1'b0;
    push_frame(1);
    pulse_start(s);
    chk("wd_err_cleared", 32'(error), 0);
    abort_m = 1'b1; step(); abort_m = 1'b0;
    eng_auto = 1'b1;
`else
    chk("no_wdog_error", 32'(error), 0);
`endif

    // Asynchronous reset at bin 50
    eng_lat = 2; iss_cnt = 0;
    push_frame(FREQ);
    pulse_start(s);
    n = 0;
    while (bin_idx != 9'd50 && n < 500) begin step(); n++; end
    chk("rst_reach_bin50", 32'(bin_idx), 50);
    #2 rst = 1'b1;
    #1 chk_all_zero("rst_async");
    step(); step();
    rst = 1'b0;
    i0 = iss_cnt;
    for (int k = 0; k < 6; k++) step();
    chk("rst_stay_idle", 32'(busy), 0);
    chk("rst_no_issue", iss_cnt, i0);
    sb.delete();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
